// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath types: store widths, store-merge FSM states and the
// alignment/legality rule used when a store is accepted.
package riscv_pkg;

    localparam int DATA_W = 64;

    typedef enum logic [2:0] {
        ST_SB = 3'd0,
        ST_SH = 3'd1,
        ST_SW = 3'd2,
        ST_SD = 3'd3
    } st_type_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_MERGE = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } smu_state_e;

    // Natural alignment per width; encodings 4..7 are never legal.
    function automatic logic st_legal(input logic [2:0] typ, input logic [2:0] off);
        logic ok;
        case (st_type_e'(typ))
            ST_SB:   ok = 1'b1;
            ST_SH:   ok = ~off[0];
            ST_SW:   ok = (off[1:0] == 2'b00);
            ST_SD:   ok = (off == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/store_byte_merge.sv
// Combinational byte-lane replacement: the addressed lanes of a doubleword take
// the right-aligned store data (little-endian), all other lanes pass through.
module store_byte_merge
    import riscv_pkg::*;
(
    input  logic [DATA_W-1:0] old_dw,
    input  logic [DATA_W-1:0] st_data,
    input  logic [2:0]        st_type,
    input  logic [2:0]        offset,
    output logic [DATA_W-1:0] merged_dw
);

    logic [7:0]        base_mask;
    logic [7:0]        lane_mask;
    logic [DATA_W-1:0] shifted;

    always_comb begin
        case (st_type_e'(st_type))
            ST_SB:   base_mask = 8'h01;
            ST_SH:   base_mask = 8'h03;
            ST_SW:   base_mask = 8'h0F;
            ST_SD:   base_mask = 8'hFF;
            default: base_mask = 8'h00;
        endcase
        // Alignment is guaranteed upstream, so the shifted mask never wraps.
        lane_mask = base_mask << offset;
        shifted   = st_data << {offset, 3'b000};
        merged_dw = old_dw;
        for (int i = 0; i < 8; i++) begin
            if (lane_mask[i]) begin
                merged_dw[8*i +: 8] = shifted[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/store_merge_unit.sv
// Read-modify-write store engine between the datapath (B register / ALU address)
// and the 64-bit data memory; st_done gates the control FSM's next state.
module store_merge_unit
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              st_req,
    input  logic [2:0]        st_type,
    input  logic [DATA_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_busy,
    output logic              st_done,
    output logic              st_err,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    smu_state_e        state_q;
    smu_state_e        state_d;
    logic [2:0]        req_type_q;
    logic [DATA_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_data_q;
    logic [DATA_W-1:0] merge_q;
    logic              err_q;
    logic              req_legal;
    logic              accept;
    logic [DATA_W-1:0] merged_dw;

    assign req_legal = st_legal(st_type, st_addr[2:0]);
    assign accept    = (state_q == S_IDLE) && st_req;

    store_byte_merge u_merge (
        .old_dw    (mem_rdata),
        .st_data   (req_data_q),
        .st_type   (req_type_q),
        .offset    (req_addr_q[2:0]),
        .merged_dw (merged_dw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (st_req) begin
                    if (!req_legal) begin
                        state_d = S_DONE;
                    end else if (st_type_e'(st_type) == ST_SD) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ:  state_d = S_MERGE;
            S_MERGE: state_d = S_WRITE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        st_busy = (state_q != S_IDLE);
        st_done = (state_q == S_DONE);
        st_err  = (state_q == S_DONE) && err_q;
        mem_wr  = (state_q == S_WRITE);
    end

    // Request latch and merge register; frozen from acceptance until DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_type_q <= '0;
            req_addr_q <= '0;
            req_data_q <= '0;
            merge_q    <= '0;
            err_q      <= 1'b0;
        end else if (accept) begin
            req_type_q <= st_type;
            req_addr_q <= st_addr;
            req_data_q <= st_data;
            err_q      <= ~req_legal;
            if (req_legal && (st_type_e'(st_type) == ST_SD)) begin
                merge_q <= st_data;
            end
        end else if (state_q == S_MERGE) begin
            merge_q <= merged_dw;
        end
    end

    assign mem_addr  = {req_addr_q[DATA_W-1:3], 3'b000};
    assign mem_wdata = merge_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: directed vectors, busy/reset sequences and
// randomized stores against a byte-level reference model with a small memory.
module tb_store_merge_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_req;
    logic [2:0]  st_type;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic        st_busy;
    logic        st_done;
    logic        st_err;
    logic [63:0] mem_addr;
    logic        mem_wr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = 64'd0;

    logic [63:0] mem [logic [63:0]];

    int n_checks = 0;
    int n_errs   = 0;

    typedef struct {
        logic [2:0]  typ;
        logic [63:0] addr;
        logic [63:0] data;
        logic [63:0] rdata;
        logic [63:0] exp_wdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    store_merge_unit dut (
        .clk       (clk),
        .rst       (rst),
        .st_req    (st_req),
        .st_type   (st_type),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_busy   (st_busy),
        .st_done   (st_done),
        .st_err    (st_err),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [63:0] mem_read(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 64'd0;
    endfunction

    // Synchronous-read data memory
    always @(posedge clk) begin
        mem_rdata <= mem_read(mem_addr);
        if (mem_wr) mem[mem_addr] = mem_wdata;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: replace bytes o..o+size-1 of the old doubleword.
    function automatic void model(input logic [2:0] typ, input logic [63:0] addr,
                                  input logic [63:0] data, input logic [63:0] old,
                                  output logic err, output int lat, output logic [63:0] wdata);
        int size = 1;
        int o = int'(addr[2:0]);
        if (typ > 3'd3) begin
            err = 1'b1;
        end else begin
            size = 1 << typ;
            err  = (o % size) != 0;
        end
        wdata = old;
        if (!err) begin
            for (int j = 0; j < size; j++) wdata[8*(o+j) +: 8] = data[8*j +: 8];
        end
        lat = err ? 1 : ((typ == 3'd3) ? 2 : 4);
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after st_done.
    task automatic run_store(input logic [2:0] typ, input logic [63:0] addr, input logic [63:0] data,
                             output int done_cyc, output logic err, output int wr_cnt,
                             output int wr_cyc, output logic [63:0] wr_data, output logic [63:0] wr_addr);
        st_req = 1'b1; st_type = typ; st_addr = addr; st_data = data;
        done_cyc = -1; err = 1'b0; wr_cnt = 0; wr_cyc = -1; wr_data = '0; wr_addr = '0;
        for (int c = 1; c <= 8 && done_cyc < 0; c++) begin
            @(negedge clk);
            st_req  = 1'b0;
            st_type = 3'($urandom);
            st_addr = {$urandom, $urandom};
            st_data = {$urandom, $urandom};
            if (mem_wr) begin
                wr_cnt++; wr_cyc = c; wr_data = mem_wdata; wr_addr = mem_addr;
            end
            if (st_done) begin
                done_cyc = c; err = st_err;
            end
        end
        @(negedge clk);
    endtask

    task automatic apply(input string name, input logic [2:0] typ, input logic [63:0] addr,
                         input logic [63:0] data, input logic [63:0] old,
                         input logic [63:0] exp_wdata, input logic exp_err, input int exp_lat);
        int done_cyc, wr_cnt, wr_cyc;
        logic err;
        logic [63:0] wr_data, wr_addr;
        mem[addr & ~64'h7] = old;
        run_store(typ, addr, data, done_cyc, err, wr_cnt, wr_cyc, wr_data, wr_addr);
        check({name, ".done_cycle"}, 64'(done_cyc), 64'(exp_lat));
        check({name, ".err"}, 64'(err), 64'(exp_err));
        check({name, ".wr_count"}, 64'(wr_cnt), exp_err ? 64'd0 : 64'd1);
        if (!exp_err) begin
            check({name, ".wr_cycle"}, 64'(wr_cyc), 64'(exp_lat - 1));
            check({name, ".wdata"}, wr_data, exp_wdata);
            check({name, ".waddr"}, wr_addr, addr & ~64'h7);
        end
        check({name, ".idle_after"}, 64'(st_busy), 64'd0);
    endtask

    initial begin
        int wr_seen;
        int done_cyc, wr_cnt, wr_cyc;
        logic err, exp_err;
        int exp_lat;
        logic [2:0]  typ;
        logic [63:0] addr, data, old, exp_w, wr_data, wr_addr, first_wdata;

        vecs[0]  = '{3'd0, 64'h103, 64'hAB, 64'h1122334455667788, 64'h11223344AB667788, 1'b0, 4};
        vecs[1]  = '{3'd1, 64'h206, 64'hBEEF, 64'hFFFFFFFFFFFFFFFF, 64'hBEEFFFFFFFFFFFFF, 1'b0, 4};
        vecs[2]  = '{3'd2, 64'h102, 64'h12345678, 64'h0, 64'h0, 1'b1, 1};
        vecs[3]  = '{3'd3, 64'h008, 64'h0123456789ABCDEF, 64'hDEADBEEFDEADBEEF, 64'h0123456789ABCDEF, 1'b0, 2};
        vecs[4]  = '{3'd2, 64'h304, 64'hCAFEBABE, 64'h0011223344556677, 64'hCAFEBABE44556677, 1'b0, 4};
        vecs[5]  = '{3'd0, 64'h400, 64'hFFFFFFFFFFFFFF5A, 64'h0, 64'h000000000000005A, 1'b0, 4};
        vecs[6]  = '{3'd1, 64'h100, 64'h1234, 64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAA1234, 1'b0, 4};
        vecs[7]  = '{3'd1, 64'h101, 64'h1234, 64'h0, 64'h0, 1'b1, 1};
        vecs[8]  = '{3'd3, 64'h004, 64'h1, 64'h0, 64'h0, 1'b1, 1};
        vecs[9]  = '{3'd7, 64'h000, 64'h1, 64'h0, 64'h0, 1'b1, 1};
        vecs[10] = '{3'd5, 64'h010, 64'h1, 64'h0, 64'h0, 1'b1, 1};

        rst = 1'b1; st_req = 1'b0; st_type = '0; st_addr = '0; st_data = '0;
        repeat (3) @(negedge clk);
        check("reset.busy", 64'(st_busy), 64'd0);
        check("reset.done", 64'(st_done), 64'd0);
        check("reset.err", 64'(st_err), 64'd0);
        check("reset.mem_wr", 64'(mem_wr), 64'd0);
        check("reset.mem_addr", mem_addr, 64'd0);
        check("reset.mem_wdata", mem_wdata, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].typ, vecs[i].addr, vecs[i].data,
                  vecs[i].rdata, vecs[i].exp_wdata, vecs[i].exp_err, vecs[i].exp_lat);
        end

        // Busy: a second request held during an SB is taken only after st_done.
        mem[64'h800] = 64'h1122334455667788;
        mem[64'h900] = 64'h0;
        st_req = 1'b1; st_type = 3'd0; st_addr = 64'h805; st_data = 64'hC3;
        wr_seen = 0; first_wdata = '0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            st_req = 1'b1; st_type = 3'd3; st_addr = 64'h900; st_data = 64'hA5A5000012345678;
            if (mem_wr) begin wr_seen++; first_wdata = mem_wdata; end
            if (c == 4) begin
                check("busy.first_done", 64'(st_done), 64'd1);
                check("busy.first_err", 64'(st_err), 64'd0);
            end
        end
        check("busy.first_wr_count", 64'(wr_seen), 64'd1);
        check("busy.first_wdata", first_wdata, 64'h1122C34455667788);
        @(negedge clk);
        check("busy.idle_after_done", 64'(st_busy), 64'd0);
        @(negedge clk);
        st_req = 1'b0;
        check("busy.second_wr", 64'(mem_wr), 64'd1);
        check("busy.second_wdata", mem_wdata, 64'hA5A5000012345678);
        check("busy.second_addr", mem_addr, 64'h900);
        @(negedge clk);
        check("busy.second_done", 64'(st_done), 64'd1);
        @(negedge clk);

        // Reset in MERGE aborts the store; rst beats a simultaneous st_req.
        mem[64'h600] = 64'hFFFF0000FFFF0000;
        st_req = 1'b1; st_type = 3'd0; st_addr = 64'h601; st_data = 64'h77;
        @(negedge clk);
        st_req = 1'b0;
        check("rstmid.read_busy", 64'(st_busy), 64'd1);
        @(negedge clk);
        check("rstmid.merge_busy", 64'(st_busy), 64'd1);
        rst = 1'b1; st_req = 1'b1; st_type = 3'd0; st_addr = 64'h700; st_data = 64'h11;
        @(negedge clk);
        check("rstmid.busy", 64'(st_busy), 64'd0);
        check("rstmid.done", 64'(st_done), 64'd0);
        check("rstmid.err", 64'(st_err), 64'd0);
        check("rstmid.mem_wr", 64'(mem_wr), 64'd0);
        check("rstmid.mem_addr", mem_addr, 64'd0);
        check("rstmid.mem_wdata", mem_wdata, 64'd0);
        @(negedge clk);
        check("rstprio.busy", 64'(st_busy), 64'd0);
        rst = 1'b0; st_req = 1'b0;
        wr_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (mem_wr || st_done) wr_seen++;
        end
        check("rstmid.no_wr_or_done", 64'(wr_seen), 64'd0);
        check("rstmid.mem_untouched", mem[64'h600], 64'hFFFF0000FFFF0000);
        run_store(3'd5, 64'h10, 64'h1, done_cyc, err, wr_cnt, wr_cyc, wr_data, wr_addr);
        check("rstmid.illegal_done", 64'(done_cyc), 64'd1);
        check("rstmid.illegal_err", 64'(err), 64'd1);
        check("rstmid.illegal_wr", 64'(wr_cnt), 64'd0);

        // Randomized stores against the byte-level model.
        for (int i = 0; i < 40; i++) begin
            typ  = 3'($urandom_range(0, 7));
            addr = {$urandom, $urandom};
            if (typ < 3'd4 && $urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << typ) - 64'd1);
            data = {$urandom, $urandom};
            old  = {$urandom, $urandom};
            mem[addr & ~64'h7] = old;
            model(typ, addr, data, old, exp_err, exp_lat, exp_w);
            run_store(typ, addr, data, done_cyc, err, wr_cnt, wr_cyc, wr_data, wr_addr);
            check($sformatf("rnd%0d.done_cycle", i), 64'(done_cyc), 64'(exp_lat));
            check($sformatf("rnd%0d.err", i), 64'(err), 64'(exp_err));
            check($sformatf("rnd%0d.wr_count", i), 64'(wr_cnt), exp_err ? 64'd0 : 64'd1);
            if (!exp_err) begin
                check($sformatf("rnd%0d.wdata", i), wr_data, exp_w);
                check($sformatf("rnd%0d.waddr", i), wr_addr, addr & ~64'h7);
                check($sformatf("rnd%0d.mem", i), mem[addr & ~64'h7], exp_w);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
